// File: rtl/cordic_serial.sv
// Bit-serial I/O CORDIC engine: one word in and one result out per frame, LSB first.
// The iterations run between input windows, so results emerge one frame after their inputs.
module cordic_serial #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16,
  parameter int GUARD = 2
) (
  input  logic clk,
  input  logic sclr,
  input  logic xi,
  input  logic yi,
  input  logic zi,
  input  logic rot,
  output logic valid,
  output logic xo,
  output logic yo,
  output logic zo
);

  localparam int PERIOD = WIDTH + 1 + ITERS + 1;
  localparam int CW     = $clog2(PERIOD);
  // Two extra integer bits absorb the CORDIC gain (~1.65) on full-scale inputs.
  localparam int IW     = WIDTH + GUARD + 2;
  localparam int IIW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int GS     = (GUARD >= 2) ? GUARD - 2 : 0;
  localparam int GR     = (GUARD < 2) ? 2 - GUARD : 0;
  localparam logic signed [IW-1:0] HALF = (GUARD > 0) ? IW'(1 << ((GUARD > 0) ? GUARD - 1 : 0)) : '0;

  // atan(2^-i) tabulated at 2^16 scale, rescaled to 2^(14+GUARD) with rounding.
  function automatic logic signed [IW-1:0] atan_rom(input logic [IIW-1:0] idx);
    int v;
    int i;
    i = int'(idx);
    case (i)
      0:       v = 51472;
      1:       v = 30386;
      2:       v = 16055;
      3:       v = 8150;
      4:       v = 4091;
      5:       v = 2047;
      6:       v = 1024;
      7:       v = 512;
      default: v = (i < 31) ? (((131072 >>> i) + 1) >>> 1) : 0;
    endcase
    atan_rom = IW'(((v <<< GS) + ((1 <<< GR) >>> 1)) >>> GR);
  endfunction

  logic [CW-1:0]          r_cnt;
  logic                   r_valid;
  logic                   r_rot;
  logic [WIDTH-1:0]       r_xin, r_yin, r_zin;
  logic [WIDTH-1:0]       r_xout, r_yout, r_zout;
  logic signed [IW-1:0]   r_x, r_y, r_z;

  logic                   w_shift, w_load, w_iter_ph, w_xfer;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IIW-1:0]         w_iter;
  logic                   w_dpos;
  logic signed [IW-1:0]   w_xl, w_yl, w_zl;
  logic signed [IW-1:0]   w_xs, w_ys, w_ang;
  logic signed [IW-1:0]   w_xn, w_yn, w_zn;
  logic signed [IW-1:0]   w_xr, w_yr, w_zr;

  assign w_shift   = (r_cnt < CW'(WIDTH));
  assign w_load    = (r_cnt == CW'(WIDTH));
  assign w_iter_ph = (r_cnt > CW'(WIDTH)) && (r_cnt < CW'(PERIOD - 1));
  assign w_xfer    = (r_cnt == CW'(PERIOD - 1));
  assign w_cnt_nxt = w_xfer ? '0 : r_cnt + CW'(1);
  assign w_iter    = IIW'(r_cnt - CW'(WIDTH + 1));

  assign w_xl = IW'($signed(r_xin)) <<< GUARD;
  assign w_yl = IW'($signed(r_yin)) <<< GUARD;
  assign w_zl = IW'($signed(r_zin)) <<< GUARD;

  assign w_dpos = r_rot ? ~r_z[IW-1] : r_y[IW-1];
  assign w_xs   = r_x >>> w_iter;
  assign w_ys   = r_y >>> w_iter;
  assign w_ang  = atan_rom(w_iter);
  assign w_xn   = w_dpos ? r_x - w_ys  : r_x + w_ys;
  assign w_yn   = w_dpos ? r_y + w_xs  : r_y - w_xs;
  assign w_zn   = w_dpos ? r_z - w_ang : r_z + w_ang;

  assign w_xr = r_x + HALF;
  assign w_yr = r_y + HALF;
  assign w_zr = r_z + HALF;

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_cnt   <= CW'(PERIOD - 1);
      r_valid <= 1'b0;
      r_rot   <= 1'b0;
      r_xin   <= '0;
      r_yin   <= '0;
      r_zin   <= '0;
      r_xout  <= '0;
      r_yout  <= '0;
      r_zout  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt < CW'(WIDTH));
      if (w_shift) begin
        r_xin  <= {xi, r_xin[WIDTH-1:1]};
        r_yin  <= {yi, r_yin[WIDTH-1:1]};
        r_zin  <= {zi, r_zin[WIDTH-1:1]};
        r_xout <= {1'b0, r_xout[WIDTH-1:1]};
        r_yout <= {1'b0, r_yout[WIDTH-1:1]};
        r_zout <= {1'b0, r_zout[WIDTH-1:1]};
      end
      if (w_load) begin
        r_x   <= w_xl;
        r_y   <= w_yl;
        r_z   <= w_zl;
        r_rot <= rot;
      end
      if (w_iter_ph) begin
        r_x <= w_xn;
        r_y <= w_yn;
        r_z <= w_zn;
      end
      // Slicing above the guard bits after adding half an LSB rounds and wraps in one step.
      if (w_xfer) begin
        r_xout <= w_xr[GUARD +: WIDTH];
        r_yout <= w_yr[GUARD +: WIDTH];
        r_zout <= w_zr[GUARD +: WIDTH];
      end
    end
  end

  assign valid = r_valid;
  assign xo    = r_xout[0];
  assign yo    = r_yout[0];
  assign zo    = r_zout[0];

endmodule

// File: tb/tb_cordic_serial.sv
// Directed bench for cordic_serial: serial framing, reset behaviour, rotation/vectoring
// results against hand values (+/-8 LSB) and against an exact integer reference.
module tb_cordic_serial;

  logic clk = 1'b0;
  logic sclr, xi, yi, zi, rot;
  logic valid, xo, yo, zo;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  cordic_serial #(.WIDTH(16), .ITERS(16), .GUARD(2)) dut (
    .clk(clk), .sclr(sclr), .xi(xi), .yi(yi), .zi(zi), .rot(rot),
    .valid(valid), .xo(xo), .yo(yo), .zo(zo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    shortint d;
    d = shortint'(obs - exp);
    n_chk++;
    assert ((d <= 8) && (d >= -8) && !$isunknown(obs)) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h +/-8", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Exact reference using wide integers; output rounding and wrap happen only at the end.
  function automatic void model(input logic [15:0] xw, input logic [15:0] yw, input logic [15:0] zw,
                                input logic rw,
                                output logic [15:0] xr, output logic [15:0] yr, output logic [15:0] zr);
    longint x, y, z, xn, yn, a;
    real p;
    x = longint'($signed(xw)) * 4;
    y = longint'($signed(yw)) * 4;
    z = longint'($signed(zw)) * 4;
    for (int i = 0; i < 16; i++) begin
      p = 1.0;
      for (int j = 0; j < i; j++) p = p / 2.0;
      a = longint'($rtoi($atan(p) * 65536.0 + 0.5));
      if (rw ? (z >= 0) : (y < 0)) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - a;
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + a;
      end
      x = xn;
      y = yn;
    end
    xr = 16'((x + 2) >>> 2);
    yr = 16'((y + 2) >>> 2);
    zr = 16'((z + 2) >>> 2);
  endfunction

  // Shifts one word in during the next valid window while capturing the outgoing word.
  // rot is held at the opposite value except in the load cycle.
  task automatic do_frame(input logic [15:0] xw, input logic [15:0] yw, input logic [15:0] zw,
                          input logic rw, input string tag,
                          output logic [15:0] xr, output logic [15:0] yr, output logic [15:0] zr,
                          output int start);
    int t;
    int vcnt;
    t = 0;
    while (valid !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk_bit({tag, "_start"}, valid, 1'b1);
    start = cyc;
    vcnt = 0;
    for (int k = 0; k < 16; k++) begin
      xi  = xw[k];
      yi  = yw[k];
      zi  = zw[k];
      rot = ~rw;
      xr[k] = xo;
      yr[k] = yo;
      zr[k] = zo;
      if (valid === 1'b1) vcnt++;
      @(negedge clk);
    end
    n_chk++;
    assert (vcnt == 16 && valid === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_window: observed %0d high cycles, valid after %b; expected 16 and 0", tag, vcnt, valid);
    end
    xi = 1'b1; yi = 1'b0; zi = 1'b1;
    rot = rw;
    @(negedge clk);
    rot = ~rw;
  endtask

  logic [15:0] xr, yr, zr, mx, my, mz;
  int s_prev, s_cur;

  initial begin
    sclr = 1'b1; xi = 1'b0; yi = 1'b0; zi = 1'b0; rot = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      xi = k[0]; yi = ~k[0]; zi = 1'b1; rot = k[1];
    end
    chk_bit("rst_valid", valid, 1'b0);
    chk_eq("rst_out", {13'd0, xo, yo, zo}, 16'd0);
    sclr = 1'b0;
    @(negedge clk);
    chk_bit("first_valid", valid, 1'b1);

    // Frame 1: pi/8 rotation in, zeros out.
    do_frame(16'h26DD, 16'h0000, 16'h1921, 1'b1, "f1", xr, yr, zr, s_prev);
    chk_eq("f1_out", xr | yr | zr, 16'h0000);

    // Frame 2: -pi/3 rotation in, pi/8 result out.
    do_frame(16'h26DD, 16'h0000, 16'hBCFA, 1'b1, "f2", xr, yr, zr, s_cur);
    chk_eq("period_2", 16'(s_cur - s_prev), 16'd34);
    s_prev = s_cur;
    chk_tol("pi8_x", xr, 16'h3B21);
    chk_tol("pi8_y", yr, 16'h187D);
    chk_tol("pi8_z", zr, 16'h0000);
    model(16'h26DD, 16'h0000, 16'h1921, 1'b1, mx, my, mz);
    chk_eq("pi8_exact", xr ^ yr ^ zr, mx ^ my ^ mz);
    chk_eq("pi8_exact_x", xr, mx);

    // Frame 3: vectoring [1,1] in, -pi/3 result out.
    do_frame(16'h1000, 16'h1000, 16'h0000, 1'b0, "f3", xr, yr, zr, s_cur);
    chk_eq("period_3", 16'(s_cur - s_prev), 16'd34);
    s_prev = s_cur;
    chk_tol("m60_x", xr, 16'h2000);
    chk_tol("m60_y", yr, 16'hC893);
    chk_tol("m60_z", zr, 16'h0000);
    model(16'h26DD, 16'h0000, 16'hBCFA, 1'b1, mx, my, mz);
    chk_eq("m60_exact_y", yr, my);

    // Frame 4: vectoring [1,-1] in, [1,1] result out.
    do_frame(16'h1000, 16'hF000, 16'h0000, 1'b0, "f4", xr, yr, zr, s_cur);
    chk_eq("period_4", 16'(s_cur - s_prev), 16'd34);
    s_prev = s_cur;
    chk_tol("v11_x", xr, 16'h2543);
    chk_tol("v11_y", yr, 16'h0000);
    chk_tol("v11_z", zr, 16'h3243);
    model(16'h1000, 16'h1000, 16'h0000, 1'b0, mx, my, mz);
    chk_eq("v11_exact_z", zr, mz);

    // Frame 5: full-scale rotation in (wraps), [1,-1] result out.
    do_frame(16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, "f5", xr, yr, zr, s_cur);
    chk_eq("period_5", 16'(s_cur - s_prev), 16'd34);
    s_prev = s_cur;
    chk_tol("v1m1_x", xr, 16'h2543);
    chk_tol("v1m1_y", yr, 16'h0000);
    chk_tol("v1m1_z", zr, 16'hCDBC);
    model(16'h1000, 16'hF000, 16'h0000, 1'b0, mx, my, mz);
    chk_eq("v1m1_exact_x", xr, mx);

    // Frame 6: wrapped result out; a new word goes in and is then aborted by reset.
    do_frame(16'h26DD, 16'h0000, 16'h1921, 1'b1, "f6", xr, yr, zr, s_cur);
    model(16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, mx, my, mz);
    chk_eq("wrap_x", xr, mx);
    chk_eq("wrap_y", yr, my);
    chk_eq("wrap_z", zr, mz);

    repeat (3) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    chk_bit("mid_rst_valid", valid, 1'b0);
    chk_eq("mid_rst_out", {13'd0, xo, yo, zo}, 16'd0);
    @(negedge clk);
    sclr = 1'b0;
    @(negedge clk);
    chk_bit("mid_rst_first_valid", valid, 1'b1);

    do_frame(16'h1000, 16'h1000, 16'h0000, 1'b0, "f7", xr, yr, zr, s_prev);
    chk_eq("abort_out", xr | yr | zr, 16'h0000);

    do_frame(16'h0000, 16'h0000, 16'h0000, 1'b1, "f8", xr, yr, zr, s_cur);
    chk_eq("period_8", 16'(s_cur - s_prev), 16'd34);
    model(16'h1000, 16'h1000, 16'h0000, 1'b0, mx, my, mz);
    chk_eq("post_rst_x", xr, mx);
    chk_eq("post_rst_z", zr, mz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_serial.md
Name: cordic_serial

Overview:
- Bit-serial-I/O CORDIC engine for 16-bit signed Q1.14 data (1.0 = 0x4000).
- Each word is a triple (x, y, z) plus a mode bit:
  - rotation mode gives x,y rotated by angle z (feeding x = 1/K, y = 0 yields cos z, sin z);
  - vectoring mode gives gained magnitude and atan(y/x).
- Words stream in and out one bit per clock, LSB first, framed by a DUT-generated valid strobe.
- Sits between serial shift-register datapaths in DSP blocks.

Parameters:
- WIDTH, 16, external word width (Q1.14 signed; x, y, z all use this format).
- ITERS, 16, CORDIC micro-rotations per word (i = 0..ITERS-1).
- GUARD, 2, extra LSB guard bits in the internal x/y/z registers.

Ports:
- clk  in  1  clock; all logic on rising edge.
- sclr  in  1  reset, synchronous and active-high.
- xi  in  1  serial x input, LSB first, sampled on clk rising edge while valid=1.
- yi  in  1  serial y input, same framing.
- zi  in  1  serial z (angle, radians Q1.14) input, same framing.
- rot  in  1  mode for the word just shifted in: 1 = rotation, 0 = vectoring.
- valid  out  1  registered; high for exactly WIDTH consecutive cycles per frame (serial I/O window).
- xo  out  1  serial x result, LSB first, registered; bit k valid in the k-th valid-high cycle.
- yo  out  1  serial y result, same framing.
- zo  out  1  serial z result, same framing.

Behaviour:
- Frame length PERIOD = WIDTH + 1 + ITERS + 1 = 34 cycles at defaults. Counter cnt 0..PERIOD-1, wrapping.
  - cnt 0..WIDTH-1 (valid=1): shift xi/yi/zi into input shift registers; shift output registers out on xo/yo/zo.
  - cnt WIDTH (load): rot sampled; input words sign-extended and left-padded by GUARD zero LSBs into working x/y/z regs.
  - next ITERS cycles: one micro-rotation per cycle with i = 0..ITERS-1.
  - last cycle (transfer): working regs rounded to nearest (drop GUARD bits, add half-LSB) and wrapped to WIDTH bits, then loaded into the output shift registers.
- Micro-rotation step:
  - d = +1 if (rot ? z >= 0 : y < 0), else d = -1.
  - x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*atan(2^-i).
  - ">>>" is arithmetic (sign-preserving) shift, truncating.
- Angle ROM: round(atan(2^-i) * 2^(14+GUARD)) for i = 0..ITERS-1; atan(1) = 0x3244 at GUARD=0 scaling.
- No gain compensation inside the block: outputs carry K ≈ 1.64676 on x/y.
- Convergence range |z| ≤ 1.74 rad (rotation); vectoring requires x > 0.
- Out-of-range results wrap modulo 2^WIDTH; no saturation, no error flag.
- Latency: the result of the word shifted in during frame n is shifted out during frame n+1. xo/yo/zo drive 0 during frame 1.
- Per-word mode: rot may change at any time; only its value at the load cycle matters.
- Reset (sclr=1 at a clock edge):
  - cnt = PERIOD-1, valid = 0;
  - all shift and working registers cleared, so xo = yo = zo = 0.
  - The first valid=1 cycle is the first clock after sclr returns low.
- sclr mid-frame aborts the in-flight computation and the partially shifted word; no stale data appears afterwards.
- sclr dominates all other activity.
- Accuracy: each output within ±8 LSB of the ideal value.

Test Plan:
- Rotation, pi/8: x=0x26DD, y=0x0000, z=0x1921, rot=1 → x≈0x3B21 (cos), y≈0x187D (sin), z≈0x0000, each ±8 LSB.
- Rotation, -pi/3: x=0x26DD, y=0, z=0xBCFA, rot=1 → x≈0x2000, y≈0xC893, z≈0.
- Vectoring, [1,1] and [1,-1]:
  - (x=0x1000, y=0x1000, z=0, rot=0) → x≈0x2543, y≈0, z≈0x3243.
  - (0x1000, 0xF000) → x≈0x2543, y≈0, z≈0xCDBC.
- Back-to-back stream (the four words above, rot switched 1→0 mid-stream after the third valid rising edge):
  - results appear one frame late, in order;
  - valid rises once every 34 cycles and stays high exactly 16 cycles.
- Reset:
  - xo/yo/zo = 0 and valid = 0 while sclr is high;
  - first valid 1 cycle after release;
  - sclr asserted mid-iteration → next output frame all zeros.
- Wraparound: rotation with x=0x7FFF, y=0x7FFF, z=0 → output wraps per modulo rule (matches a bit-accurate model), no hang.
